// File: rtl/bram_dump_streamer_pkg.sv
// Shared constants for the BRAM dump streamer.
//   dump_state_t    : FSM state register type
//   DUMP_*          : FSM state encodings (CSUM only reached with BRAM_DUMP_CHECKSUM_EN)
//   DUMP_ADDR_STEP  : byte stride between consecutive 32-bit words
//   DUMP_DATA_W     : default word width, matches the BRAM data width
package bram_dump_streamer_pkg;

  typedef logic [2:0] dump_state_t;

  localparam dump_state_t DUMP_IDLE = 3'd0;
  localparam dump_state_t DUMP_READ = 3'd1;
  localparam dump_state_t DUMP_SEND = 3'd2;
  localparam dump_state_t DUMP_DONE = 3'd3;
  localparam dump_state_t DUMP_CSUM = 3'd4;

  localparam int unsigned DUMP_ADDR_STEP = 4;
  localparam int unsigned DUMP_DATA_W    = 32;

endpackage

// File: rtl/bram_dump_streamer_stream_out_reg.sv
// Holding register for one valid/ready output beat.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_load            : capture i_data/i_addr/i_last and raise o_valid (wins over i_clear)
//   i_clear           : drop o_valid/o_last after a handshake
//   o_valid, o_data, o_addr, o_last : registered beat; held unchanged while neither strobe is set
module bram_dump_streamer_stream_out_reg
  import bram_dump_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = DUMP_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_last,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      // Load beats clear: the checksum beat is loaded on the last data handshake.
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_addr  <= i_addr;
      r_last  <= i_last;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_addr  = r_addr;
  assign o_last  = r_last;

endmodule

// File: rtl/bram_dump_streamer.sv
// Reads word_count words starting at base_addr through a bram32 debug read port and streams
// them out over valid/ready. Only debug_addr is driven, so CPU-side BRAM traffic is untouched.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_start                 : begin a dump (sampled only when idle)
//   i_base_addr             : first byte address, bits [1:0] ignored
//   i_word_count            : words to dump, 0 allowed, counts past the memory size wrap
//   o_debug_addr            : to bram32 debug_addr
//   i_debug_data            : from bram32 debug_data (asynchronous read)
//   o_m_valid, i_m_ready    : output handshake
//   o_m_data, o_m_addr      : beat word and its byte address
//   o_m_last                : final beat of the dump
//   o_busy                  : dump in progress
//   o_done                  : one-cycle completion pulse
// Optional feature: define BRAM_DUMP_CHECKSUM_EN to append a running-sum beat after the data.
module bram_dump_streamer
  import bram_dump_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = DUMP_DATA_W,
  parameter int unsigned CNT_W  = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_word_count,
  output logic [ADDR_W-1:0] o_debug_addr,
  input  logic [DATA_W-1:0] i_debug_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic              o_m_last,
  output logic              o_busy,
  output logic              o_done
);

  dump_state_t       r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_done;

  dump_state_t       w_state_nxt;
  logic              w_hs;
  logic              w_last_data;
  logic              w_load;
  logic              w_clear;
  logic [DATA_W-1:0] w_ld_data;
  logic [ADDR_W-1:0] w_ld_addr;
  logic              w_ld_last;
  logic [ADDR_W-1:0] w_base_aligned;

`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif

  assign w_hs           = o_m_valid & i_m_ready;
  assign w_last_data    = (r_remaining == CNT_W'(1));
  assign w_base_aligned = i_base_addr & ~ADDR_W'(3);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_ld_data   = i_debug_data;
    w_ld_addr   = r_cur_addr;
`ifdef BRAM_DUMP_CHECKSUM_EN
    // The checksum beat carries the last flag, so data beats never do.
    w_ld_last   = 1'b0;
`else
    w_ld_last   = w_last_data;
`endif
    case (r_state)
      DUMP_IDLE: begin
        if (i_start) begin
          if (i_word_count == '0) begin
`ifdef BRAM_DUMP_CHECKSUM_EN
            w_state_nxt = DUMP_CSUM;
            w_load      = 1'b1;
            w_ld_data   = '0;
            w_ld_addr   = '0;
            w_ld_last   = 1'b1;
`else
            w_state_nxt = DUMP_DONE;
`endif
          end else begin
            w_state_nxt = DUMP_READ;
          end
        end
      end
      DUMP_READ: begin
        w_load      = 1'b1;
        w_state_nxt = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (w_hs) begin
          w_clear = 1'b1;
          if (w_last_data) begin
`ifdef BRAM_DUMP_CHECKSUM_EN
            w_state_nxt = DUMP_CSUM;
            w_load      = 1'b1;
            w_ld_data   = r_sum + o_m_data;
            w_ld_addr   = '0;
            w_ld_last   = 1'b1;
`else
            w_state_nxt = DUMP_DONE;
`endif
          end else begin
            w_state_nxt = DUMP_READ;
          end
        end
      end
`ifdef BRAM_DUMP_CHECKSUM_EN
      DUMP_CSUM: begin
        if (w_hs) begin
          w_clear     = 1'b1;
          w_state_nxt = DUMP_DONE;
        end
      end
`endif
      DUMP_DONE: w_state_nxt = DUMP_IDLE;
      default:   w_state_nxt = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= DUMP_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == DUMP_DONE);
      if (r_state == DUMP_IDLE && i_start) begin
        r_cur_addr  <= w_base_aligned;
        r_remaining <= i_word_count;
`ifdef BRAM_DUMP_CHECKSUM_EN
        r_busy      <= 1'b1;
`else
        // An empty dump goes straight to DONE and never reports busy.
        r_busy      <= (i_word_count != '0);
`endif
      end
      if (r_state == DUMP_SEND && w_hs) begin
        r_remaining <= r_remaining - CNT_W'(1);
        if (!w_last_data) begin
          r_cur_addr <= r_cur_addr + ADDR_W'(DUMP_ADDR_STEP);
        end
      end
      if (r_state == DUMP_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

`ifdef BRAM_DUMP_CHECKSUM_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= '0;
    end else if (r_state == DUMP_IDLE && i_start) begin
      r_sum <= '0;
    end else if (r_state == DUMP_SEND && w_hs) begin
      r_sum <= r_sum + o_m_data;
    end
  end
`endif

  bram_dump_streamer_stream_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_stream_out_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_data  (w_ld_data),
    .i_addr  (w_ld_addr),
    .i_last  (w_ld_last),
    .o_valid (o_m_valid),
    .o_data  (o_m_data),
    .o_addr  (o_m_addr),
    .o_last  (o_m_last)
  );

  // The debug port always shows the current word address; it is only consumed in READ.
  assign o_debug_addr = r_cur_addr;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
